// File: rtl/xiyiji_pkg.sv
// Shared types, program tables and display decode for the washing-machine controller.
package xiyiji_pkg;

   localparam int unsigned CLK_DIV  = 100;
   localparam int unsigned DEB_CYC  = 3;
   localparam int unsigned DIV_W    = $clog2(CLK_DIV);
   localparam int unsigned SEC_W    = 4;
   localparam int unsigned CNT_W    = 6;
   localparam int unsigned DONE_SEC = 3;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_INLET = 3'd1,
      ST_WASH  = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DRY   = 3'd4,
      ST_DONE  = 3'd5,
      ST_PAUSE = 3'd6
   } state_t;

   typedef struct packed {
      state_t             st;
      logic [SEC_W-1:0]   sec;
   } phase_sel_t;

   // One row per program, nibbles are {inlet, wash, drain, dry} seconds
   localparam logic [3:0][15:0] PHASE_TBL = {16'h000A, 16'h5F58, 16'h4C46, 16'h3834};

   function automatic logic [SEC_W-1:0] phase_sec(input logic [1:0] mode, input logic [1:0] ph);
      logic [15:0] row;
      row = PHASE_TBL[mode];
      case (ph)
         2'd0:    phase_sec = row[15:12];
         2'd1:    phase_sec = row[11:8];
         2'd2:    phase_sec = row[7:4];
         default: phase_sec = row[3:0];
      endcase
   endfunction

   function automatic logic [CNT_W-1:0] program_total(input logic [1:0] mode);
      program_total = CNT_W'(phase_sec(mode, 2'd0)) + CNT_W'(phase_sec(mode, 2'd1))
                    + CNT_W'(phase_sec(mode, 2'd2)) + CNT_W'(phase_sec(mode, 2'd3));
   endfunction

   // Lowest non-zero phase at index >= first; falls through to DONE when none remain
   function automatic phase_sel_t next_phase(input logic [1:0] mode, input logic [2:0] first);
      phase_sel_t sel;
      sel.st  = ST_DONE;
      sel.sec = SEC_W'(DONE_SEC);
      for (int i = 3; i >= 0; i--) begin
         if ((3'(i) >= first) && (phase_sec(mode, 2'(i)) != '0)) begin
            sel.st  = state_t'(3'(i + 1));
            sel.sec = phase_sec(mode, 2'(i));
         end
      end
      return sel;
   endfunction

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 7'b1111110;
         4'd1:    seg7 = 7'b0110000;
         4'd2:    seg7 = 7'b1101101;
         4'd3:    seg7 = 7'b1111001;
         4'd4:    seg7 = 7'b0110011;
         4'd5:    seg7 = 7'b1011011;
         4'd6:    seg7 = 7'b1011111;
         4'd7:    seg7 = 7'b1110000;
         4'd8:    seg7 = 7'b1111111;
         4'd9:    seg7 = 7'b1111011;
         default: seg7 = 7'b0000000;
      endcase
   endfunction

endpackage

// File: rtl/xiyiji_debounce.sv
// Single-bit debouncer: output follows the input after CYC consecutive differing samples.
module xiyiji_debounce
   import xiyiji_pkg::*;
#(
   parameter int unsigned CYC     = DEB_CYC,
   parameter logic        RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic i_raw,
   output logic o_deb
);

   localparam int unsigned CW = $clog2(CYC + 1);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
         o_deb <= RST_VAL;
      end else if (i_raw == o_deb) begin
         r_cnt <= '0;
      end else if (r_cnt == CW'(CYC - 1)) begin
         r_cnt <= '0;
         o_deb <= i_raw;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/xiyiji_washer_top.sv
// Washing-machine controller: button debounce, 1 Hz divider, program sequencer and
// multiplexed two-digit display, sitting directly on board pins.
module xiyiji_washer_top
   import xiyiji_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       select,
   input  logic       start,
   input  logic       emergency,
   output logic       select_qudou,
   output logic       start_qudou,
   output logic       emergency_qudou,
   output logic       rst_qudou,
   output logic       clk_1hz,
   output logic [1:0] mode_c,
   output logic [2:0] tmp,
   output logic [3:0] time_c,
   output logic [3:0] c_s,
   output logic [5:0] count,
   output logic       zheng,
   output logic       fan,
   output logic       inlet,
   output logic       drain,
   output logic       dry,
   output logic       ledzheng,
   output logic       ledfan,
   output logic       ledinlet,
   output logic       leddrain,
   output logic       leddry,
   output logic       ledstop,
   output logic       alarm,
   output logic       enable_xiyiji,
   output logic [6:0] discode,
   output logic [1:0] enable_shumaguan
);

   state_t           r_state, r_saved, w_state_n, w_saved_n;
   logic [DIV_W-1:0] r_div;
   logic             r_sel_d, r_start_d;
   logic [SEC_W-1:0] w_time_n;
   logic [3:0]       w_cs_n;
   logic [CNT_W-1:0] w_count_n, w_total;
   logic [1:0]       w_mode_n, w_en_n;
   logic             w_sec_tick, w_half, w_clk_1hz_n, w_sel_rise, w_start_acc;
   logic             w_zheng_n, w_fan_n, w_alarm_n;
   logic [3:0]       w_tens, w_units;
   logic [6:0]       w_discode_n;
   phase_sel_t       w_first, w_next;

   xiyiji_debounce #(.CYC(DEB_CYC), .RST_VAL(1'b0)) u_deb_sel   (.clk(clk), .rst(rst), .i_raw(select),    .o_deb(select_qudou));
   xiyiji_debounce #(.CYC(DEB_CYC), .RST_VAL(1'b0)) u_deb_start (.clk(clk), .rst(rst), .i_raw(start),     .o_deb(start_qudou));
   xiyiji_debounce #(.CYC(DEB_CYC), .RST_VAL(1'b0)) u_deb_emg   (.clk(clk), .rst(rst), .i_raw(emergency), .o_deb(emergency_qudou));
   xiyiji_debounce #(.CYC(DEB_CYC), .RST_VAL(1'b1)) u_deb_rst   (.clk(clk), .rst(rst), .i_raw(rst),       .o_deb(rst_qudou));

   assign tmp         = r_state;
   assign w_sec_tick  = (r_div == DIV_W'(CLK_DIV - 1));
   assign w_half      = (r_div == DIV_W'(CLK_DIV / 2 - 1));
   assign w_clk_1hz_n = clk_1hz ^ (w_sec_tick | w_half);
   assign w_sel_rise  = select_qudou & ~r_sel_d;
   assign w_start_acc = (r_state == ST_IDLE) & start_qudou & ~r_start_d;
   assign w_first     = next_phase(mode_c, 3'd0);
   assign w_next      = next_phase(mode_c, 3'(r_state));
   assign w_total     = program_total(mode_c);

   // Divider restarts on start acceptance so the first second is a full one
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_div     <= '0;
         clk_1hz   <= 1'b0;
         r_sel_d   <= 1'b0;
         r_start_d <= 1'b0;
      end else begin
         clk_1hz   <= w_clk_1hz_n;
         r_sel_d   <= select_qudou;
         r_start_d <= start_qudou;
         r_div     <= (w_start_acc || w_sec_tick) ? '0 : r_div + 1'b1;
      end
   end

   always_comb begin
      w_state_n = r_state;
      w_saved_n = r_saved;
      w_time_n  = time_c;
      w_cs_n    = c_s;
      w_count_n = count;
      w_mode_n  = mode_c;
      case (r_state)
         ST_IDLE: begin
            if (w_sel_rise) w_mode_n = mode_c + 2'd1;
            if (w_start_acc) begin
               w_state_n = w_first.st;
               w_time_n  = w_first.sec;
               w_count_n = w_total;
               w_cs_n    = '0;
            end
         end
         ST_INLET, ST_WASH, ST_DRAIN, ST_DRY: begin
            if (emergency_qudou) begin
               w_saved_n = r_state;
               w_state_n = ST_PAUSE;
            end else if (w_sec_tick) begin
               w_count_n = count - 6'd1;
               if (r_state == ST_WASH) w_cs_n = {1'b0, c_s[2:0] + 3'd1};
               if (time_c == 4'd1) begin
                  w_state_n = w_next.st;
                  w_time_n  = w_next.sec;
                  w_cs_n    = '0;
               end else begin
                  w_time_n = time_c - 4'd1;
               end
            end
         end
         ST_DONE: begin
            if (w_sec_tick) begin
               if (time_c == 4'd1) begin
                  w_state_n = ST_IDLE;
                  w_time_n  = '0;
                  w_count_n = '0;
               end else begin
                  w_time_n = time_c - 4'd1;
               end
            end
         end
         ST_PAUSE: begin
            if (!emergency_qudou) w_state_n = r_saved;
         end
         default: w_state_n = ST_IDLE;
      endcase
   end

   // Output decode from next-state values so registered outputs line up with tmp
   always_comb begin
      w_zheng_n = (w_state_n == ST_WASH) && (w_cs_n <= 4'd2);
      w_fan_n   = (w_state_n == ST_WASH) && (w_cs_n >= 4'd4) && (w_cs_n <= 4'd6);
      w_alarm_n = 1'b0;
      case (w_state_n)
         ST_PAUSE: w_alarm_n = w_clk_1hz_n;
         ST_DONE:  w_alarm_n = emergency_qudou ? w_clk_1hz_n : 1'b1;
         ST_IDLE:  w_alarm_n = emergency_qudou & w_clk_1hz_n;
         default:  w_alarm_n = 1'b0;
      endcase
      w_en_n  = {enable_shumaguan[0], enable_shumaguan[1]};
      w_tens  = 4'(count / 6'd10);
      w_units = 4'(count % 6'd10);
      if (r_state == ST_IDLE) w_discode_n = w_en_n[1] ? 7'b0000000 : seg7({2'b00, mode_c});
      else                    w_discode_n = seg7(w_en_n[1] ? w_tens : w_units);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state          <= ST_IDLE;
         r_saved          <= ST_IDLE;
         time_c           <= '0;
         c_s              <= '0;
         count            <= '0;
         mode_c           <= '0;
         {zheng, fan, inlet, drain, dry}                <= '0;
         {ledzheng, ledfan, ledinlet, leddrain, leddry} <= '0;
         ledstop          <= 1'b0;
         alarm            <= 1'b0;
         enable_xiyiji    <= 1'b0;
         discode          <= '0;
         enable_shumaguan <= 2'b01;
      end else begin
         r_state          <= w_state_n;
         r_saved          <= w_saved_n;
         time_c           <= w_time_n;
         c_s              <= w_cs_n;
         count            <= w_count_n;
         mode_c           <= w_mode_n;
         zheng            <= w_zheng_n;
         fan              <= w_fan_n;
         inlet            <= (w_state_n == ST_INLET);
         drain            <= (w_state_n == ST_DRAIN);
         dry              <= (w_state_n == ST_DRY);
         ledzheng         <= w_zheng_n;
         ledfan           <= w_fan_n;
         ledinlet         <= (w_state_n == ST_INLET);
         leddrain         <= (w_state_n == ST_DRAIN);
         leddry           <= (w_state_n == ST_DRY);
         ledstop          <= ~w_zheng_n & ~w_fan_n;
         alarm            <= w_alarm_n;
         enable_xiyiji    <= (w_state_n != ST_IDLE);
         discode          <= w_discode_n;
         enable_shumaguan <= w_en_n;
      end
   end

endmodule

// File: tb/tb_xiyiji_washer_top.sv
// Directed bench for the washer controller with hand-computed expectations.
module tb_xiyiji_washer_top;

   logic       clk = 1'b0;
   logic       rst, select, start, emergency;
   logic       select_qudou, start_qudou, emergency_qudou, rst_qudou, clk_1hz;
   logic [1:0] mode_c, enable_shumaguan;
   logic [2:0] tmp;
   logic [3:0] time_c, c_s;
   logic [5:0] count;
   logic       zheng, fan, inlet, drain, dry;
   logic       ledzheng, ledfan, ledinlet, leddrain, leddry, ledstop, alarm, enable_xiyiji;
   logic [6:0] discode;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   xiyiji_washer_top dut (
      .clk(clk), .rst(rst), .select(select), .start(start), .emergency(emergency),
      .select_qudou(select_qudou), .start_qudou(start_qudou), .emergency_qudou(emergency_qudou),
      .rst_qudou(rst_qudou), .clk_1hz(clk_1hz), .mode_c(mode_c), .tmp(tmp), .time_c(time_c),
      .c_s(c_s), .count(count), .zheng(zheng), .fan(fan), .inlet(inlet), .drain(drain), .dry(dry),
      .ledzheng(ledzheng), .ledfan(ledfan), .ledinlet(ledinlet), .leddrain(leddrain),
      .leddry(leddry), .ledstop(ledstop), .alarm(alarm), .enable_xiyiji(enable_xiyiji),
      .discode(discode), .enable_shumaguan(enable_shumaguan)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_tmp(input logic [2:0] want, input int budget, input string tag);
      int n;
      n = 0;
      while (tmp !== want && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(tag, 32'(tmp), 32'(want));
   endtask

   task automatic pulse_select();
      select = 1'b1;
      tick(10);
      select = 1'b0;
      tick(10);
   endtask

   task automatic press_start();
      int n;
      start = 1'b1;
      n = 0;
      while (tmp == 3'd0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      start = 1'b0;
      check("start_accept", 32'(tmp != 3'd0), 32'd1);
   endtask

   task automatic release_reset();
      @(negedge clk);
      rst = 1'b0;
      tick(1);
      check("rst_qudou_rel1", 32'(rst_qudou), 32'd1);
      tick(1);
      check("rst_qudou_rel2", 32'(rst_qudou), 32'd1);
      tick(1);
      check("rst_qudou_rel3", 32'(rst_qudou), 32'd0);
   endtask

   task automatic check_disp(input string tag, input logic [6:0] tens, input logic [6:0] units);
      if (enable_shumaguan == 2'b10) check({tag, "_tens"}, 32'(discode), 32'(tens));
      else                           check({tag, "_units"}, 32'(discode), 32'(units));
   endtask

   initial begin
      logic [7:0] exp_zheng, exp_fan, exp_stop;
      int         bad_alarm, bad_count, n;
      logic       saw_hi, saw_lo;

      rst = 1'b1; select = 1'b0; start = 1'b0; emergency = 1'b0;
      exp_zheng = 8'b0000_0111;
      exp_fan   = 8'b0111_0000;
      exp_stop  = 8'b1000_1000;

      tick(5);
      check("rst_tmp", 32'(tmp), 32'd0);
      check("rst_mode", 32'(mode_c), 32'd0);
      check("rst_act", 32'({zheng, fan, inlet, drain, dry}), 32'd0);
      check("rst_alarm", 32'(alarm), 32'd0);
      check("rst_count", 32'(count), 32'd0);
      check("rst_en_seg", 32'(enable_shumaguan), 32'b01);
      check("rst_discode", 32'(discode), 32'd0);
      check("rst_qudou_hi", 32'(rst_qudou), 32'd1);
      release_reset();
      tick(2);

      // program select, wrap and glitch rejection
      pulse_select();
      check("mode_after1", 32'(mode_c), 32'd1);
      pulse_select();
      pulse_select();
      check("mode_after3", 32'(mode_c), 32'd3);
      select = 1'b1;
      tick(1);
      select = 1'b0;
      tick(10);
      check("mode_glitch", 32'(mode_c), 32'd3);
      check_disp("idle_disp_a", 7'b0000000, 7'b1111001);
      tick(1);
      check_disp("idle_disp_b", 7'b0000000, 7'b1111001);

      // emergency while idle: alarm blinks, no state change
      emergency = 1'b1;
      tick(10);
      bad_alarm = 0; saw_hi = 1'b0; saw_lo = 1'b0;
      for (int i = 0; i < 200; i++) begin
         tick(1);
         if (alarm !== clk_1hz) bad_alarm++;
         if (alarm === 1'b1) saw_hi = 1'b1;
         if (alarm === 1'b0) saw_lo = 1'b1;
      end
      check("idle_emg_tmp", 32'(tmp), 32'd0);
      check("idle_emg_alarm_follow", 32'(bad_alarm), 32'd0);
      check("idle_emg_alarm_blink", 32'({saw_hi, saw_lo}), 32'b11);
      emergency = 1'b0;
      tick(10);
      check("idle_emg_off", 32'(alarm), 32'd0);

      // mode 3: dry only, select ignored while running
      press_start();
      check("m3_tmp", 32'(tmp), 32'd4);
      check("m3_count", 32'(count), 32'd10);
      check("m3_time", 32'(time_c), 32'd10);
      check("m3_act", 32'({zheng, fan, inlet, drain, dry, leddry}), 32'b000011);
      pulse_select();
      check("m3_sel_ignored", 32'(mode_c), 32'd3);
      wait_tmp(3'd0, 1500, "m3_back_idle");
      check("m3_idle_count", 32'(count), 32'd0);
      check("m3_idle_mode", 32'(mode_c), 32'd3);
      check("m3_idle_en", 32'(enable_xiyiji), 32'd0);
      pulse_select();
      check("mode_wrap", 32'(mode_c), 32'd0);

      // mode 0 full run with exact phase timing
      press_start();
      check("r1_tmp", 32'(tmp), 32'd1);
      check("r1_inlet", 32'({inlet, ledinlet}), 32'b11);
      check("r1_count", 32'(count), 32'd18);
      check("r1_time", 32'(time_c), 32'd3);
      check("r1_en", 32'(enable_xiyiji), 32'd1);
      tick(1);
      check_disp("r1_disp_a", 7'b0110000, 7'b1111111);
      tick(1);
      check_disp("r1_disp_b", 7'b0110000, 7'b1111111);
      tick(297);
      check("r1_inlet_end", 32'(tmp), 32'd1);
      tick(1);
      check("r1_wash", 32'(tmp), 32'd2);
      check("r1_wash_count", 32'(count), 32'd15);
      for (int s = 0; s < 8; s++) begin
         check($sformatf("r1_cs%0d", s), 32'(c_s), 32'(s));
         check($sformatf("r1_zheng%0d", s), 32'({zheng, ledzheng}), 32'({2{exp_zheng[s]}}));
         check($sformatf("r1_fan%0d", s), 32'({fan, ledfan}), 32'({2{exp_fan[s]}}));
         check($sformatf("r1_stop%0d", s), 32'(ledstop), 32'(exp_stop[s]));
         tick(100);
      end
      check("r1_drain", 32'(tmp), 32'd3);
      check("r1_drain_act", 32'({zheng, fan, inlet, drain, dry}), 32'b00010);
      check("r1_drain_count", 32'(count), 32'd7);
      tick(300);
      check("r1_dry", 32'(tmp), 32'd4);
      check("r1_dry_count", 32'(count), 32'd4);
      tick(400);
      check("r1_done", 32'(tmp), 32'd5);
      check("r1_done_count", 32'(count), 32'd0);
      check("r1_done_alarm", 32'(alarm), 32'd1);
      check("r1_done_act", 32'({zheng, fan, inlet, drain, dry}), 32'd0);
      tick(299);
      check("r1_done_end", 32'({tmp, alarm}), 32'({3'd5, 1'b1}));
      tick(1);
      check("r1_idle", 32'(tmp), 32'd0);
      check("r1_idle_en", 32'(enable_xiyiji), 32'd0);
      check("r1_idle_alarm", 32'(alarm), 32'd0);
      tick(1);
      check_disp("r1_idle_disp", 7'b0000000, 7'b1111110);

      // mode 0 run with emergency pause at count 10
      press_start();
      tick(800);
      check("r2_pre_tmp", 32'(tmp), 32'd2);
      check("r2_pre_count", 32'(count), 32'd10);
      emergency = 1'b1;
      wait_tmp(3'd6, 20, "r2_pause");
      check("r2_pause_act", 32'({zheng, fan, inlet, drain, dry}), 32'd0);
      check("r2_pause_count", 32'(count), 32'd10);
      check("r2_pause_time", 32'(time_c), 32'd3);
      check("r2_pause_cs", 32'(c_s), 32'd5);
      bad_alarm = 0; bad_count = 0; saw_hi = 1'b0; saw_lo = 1'b0;
      for (int i = 0; i < 500; i++) begin
         tick(1);
         if (alarm !== clk_1hz) bad_alarm++;
         if (count !== 6'd10 || tmp !== 3'd6) bad_count++;
         if (alarm === 1'b1) saw_hi = 1'b1;
         if (alarm === 1'b0) saw_lo = 1'b1;
      end
      check("r2_pause_frozen", 32'(bad_count), 32'd0);
      check("r2_pause_alarm_follow", 32'(bad_alarm), 32'd0);
      check("r2_pause_alarm_blink", 32'({saw_hi, saw_lo}), 32'b11);
      emergency = 1'b0;
      n = 0;
      while (tmp == 3'd6 && n < 20) begin
         tick(1);
         n++;
      end
      check("r2_resume_tmp", 32'(tmp), 32'd2);
      check("r2_resume_count", 32'(count), 32'd10);
      check("r2_resume_time", 32'(time_c), 32'd3);
      check("r2_resume_fan", 32'({c_s, fan}), 32'({4'd5, 1'b1}));
      wait_tmp(3'd5, 1200, "r2_done");
      check("r2_done_count", 32'(count), 32'd0);
      wait_tmp(3'd0, 400, "r2_idle");

      // asynchronous reset mid-run
      press_start();
      tick(50);
      rst = 1'b1;
      #1;
      check("r3_rst_tmp", 32'(tmp), 32'd0);
      check("r3_rst_act", 32'({zheng, fan, inlet, drain, dry}), 32'd0);
      check("r3_rst_qudou", 32'(rst_qudou), 32'd1);
      check("r3_rst_count", 32'(count), 32'd0);
      release_reset();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
